parity_frame_rx_ctrl: RTL and testbench
=======================================

# parity_frame_rx_ctrl

Serial frame controller that feeds the 4-bit even-parity checking datapath. It collects a start-delimited serial frame of four data bits (a, b, c, d) plus one parity bit p, and evaluates even parity over all five bits. It presents the nibble and the check result to downstream logic through a valid/ack handshake, and optionally counts parity errors. It sits between a bit-serial source and consumers of checked nibbles.

## Interface
- ERR_CNT_W, 8, width of the saturating parity-error counter.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  frame start strobe; honoured only in IDLE.
- sin_valid  in  1  qualifies sin for one cycle.
- sin  in  1  serial bit; order a, b, c, d, p (a first).
- abort  in  1  synchronous frame abort.
- frame_ack  in  1  consumer accepts the held frame.
- err_clr  in  1  synchronous clear of err_cnt.
- busy  out  1  high in SHIFT or HOLD.
- frame_valid  out  1  held frame available (HOLD state).
- data_out  out  4  received nibble {a,b,c,d}, with a as the MSB.
- pec_err  out  1  a^b^c^d^p; 1 = parity error.
- err_cnt  out  ERR_CNT_W  count of frames with pec_err=1, saturating.

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: collects bits; a 3-bit counter bit_idx runs 0..4.
  - HOLD: presents the frame.
- IDLE -> SHIFT on start. bit_idx is cleared. sin_valid in the same cycle as start is ignored.
- SHIFT, sin_valid=1:
  - bit_idx 0..3: sin is shifted into the data register, MSB first.
  - bit_idx 4: sin is the parity bit. pec_err is registered as XOR of the 4 data bits and sin, and the FSM goes to HOLD.
- SHIFT, sin_valid=0: no change. Gaps of any length are legal.
- SHIFT, abort=1: go to IDLE. Partial data is discarded and data_out/pec_err keep their previous values. abort has priority over sin_valid in the same cycle. abort in IDLE or HOLD is ignored.
- HOLD: frame_valid=1. data_out and pec_err are stable until frame_ack. frame_ack=1 -> IDLE.
  - start in HOLD is ignored, even when it coincides with frame_ack.
  - sin_valid in HOLD is ignored; the source must not send.
- Error counter: increments by 1 on the SHIFT->HOLD transition when the new pec_err=1. It saturates at 2^ERR_CNT_W-1.
  - err_clr sets it to 0.
  - err_clr has priority over a coincident increment.
- Reset (any state, including mid-frame): FSM=IDLE, bit_idx=0, busy=0, frame_valid=0, data_out=0, pec_err=0, err_cnt=0. Reset is applied asynchronously and released synchronously to clk by the system.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- start sampled at edge N -> busy=1 after edge N.
- The 5th valid bit (p) sampled at edge M -> frame_valid=1, data_out and pec_err valid after edge M.
- frame_ack sampled at edge K -> frame_valid=0, busy=0 after edge K. The earliest next start is sampled at edge K+1.
- Minimum frame period is 7 cycles: start, 5 bits, ack.
- err_cnt updates after the same edge that raises frame_valid.

## Configuration
- PARITY_ERR_CNT_EN defined: the error counter and err_clr are implemented as described.
- PARITY_ERR_CNT_EN undefined:
  - err_cnt is tied to 0 and err_clr is ignored; no counter flops are synthesised.
  - All other behaviour is identical.

## Test plan
- Clean frame: start, then bits 1,0,1,1,p=1 on consecutive cycles -> frame_valid after the 6th edge, data_out=4'b1011, pec_err=0, err_cnt=0. frame_ack -> frame_valid=0, busy=0 next cycle.
- Bad parity: start, bits 1,0,1,1,p=0 -> data_out=4'b1011, pec_err=1, err_cnt=1. Repeat with 0,0,0,0,p=1 -> pec_err=1, err_cnt=2.
- Gapped input: start, then the bits of 0,1,1,0,p=0 each separated by 3 idle cycles of sin_valid=0 -> data_out=4'b0110, pec_err=0, frame_valid only after the 5th valid bit.
- Abort and ignores:
  - After a completed frame with data_out=4'b1011, start a new frame and send 3 bits, then abort -> IDLE, busy=0, no frame_valid, data_out stays 4'b1011, err_cnt unchanged.
  - start+sin_valid in the same IDLE cycle -> that bit is not captured.
  - start while in HOLD -> ignored.
- Reset mid-frame: assert rst_n=0 asynchronously (between clock edges) after 2 bits -> busy, frame_valid, data_out, pec_err and err_cnt read 0 immediately, before the next clk edge. After release, a clean frame 1,1,1,1,p=0 -> data_out=4'b1111, pec_err=0.
- Saturation (PARITY_ERR_CNT_EN defined, ERR_CNT_W=2):
  - 4 bad frames -> err_cnt=3, which is held.
  - err_clr coincident with a bad-frame completion -> err_cnt=0.
  - Rebuild with the macro undefined: err_cnt stays 0 throughout.

Source files
------------

// File: rtl/parity_frame_rx_if.sv
// Handshake bundle between a bit-serial source/consumer and parity_frame_rx_ctrl.
// master = source/consumer side, slave = controller side.
interface parity_frame_rx_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 start;
  logic                 sin_valid;
  logic                 sin;
  logic                 abort;
  logic                 frame_ack;
  logic                 err_clr;
  logic                 busy;
  logic                 frame_valid;
  logic [3:0]           data_out;
  logic                 pec_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output start, sin_valid, sin, abort, frame_ack, err_clr,
    input  busy, frame_valid, data_out, pec_err, err_cnt
  );

  modport slave (
    input  start, sin_valid, sin, abort, frame_ack, err_clr,
    output busy, frame_valid, data_out, pec_err, err_cnt
  );
endinterface

// File: rtl/parity_frame_rx_ctrl.sv
// Collects a start-delimited serial frame {a,b,c,d,p}, checks even parity and holds it for a valid/ack consumer.
// Optional saturating parity-error counter is built only when PARITY_ERR_CNT_EN is defined.
module parity_frame_rx_ctrl #(
  parameter int ERR_CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  parity_frame_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e     state_q;
  logic [2:0] bit_idx_q;
  logic [3:0] shift_q;
  logic [3:0] data_out_q;
  logic       pec_err_q;
  logic       busy_q;
  logic       frame_valid_q;
  logic       new_pec;

  // Parity over the four collected data bits plus the incoming parity bit.
  assign new_pec = (^shift_q) ^ bus.sin;

  // NOTE: every state and output register is written with <= in one clocked block, so all outputs are flops with no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_idx_q     <= 3'd0;
      shift_q       <= 4'd0;
      data_out_q    <= 4'd0;
      pec_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= SHIFT;
            bit_idx_q <= 3'd0;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bus.sin_valid) begin
            if (bit_idx_q == 3'd4) begin
              data_out_q    <= shift_q;
              pec_err_q     <= new_pec;
              frame_valid_q <= 1'b1;
              state_q       <= HOLD;
            end else begin
              shift_q   <= {shift_q[2:0], bus.sin};
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        HOLD: begin
          // start and sin_valid are deliberately not looked at here.
          if (bus.frame_ack) begin
            state_q       <= IDLE;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          busy_q        <= 1'b0;
          frame_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.data_out    = data_out_q;
  assign bus.pec_err     = pec_err_q;

`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 frame_done;

  assign frame_done = (state_q == SHIFT) && !bus.abort && bus.sin_valid && (bit_idx_q == 3'd4);

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (bus.err_clr) begin
      err_cnt_q <= '0;
    end else if (frame_done && new_pec && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = bus.err_clr;
  assign bus.err_cnt    = '0;
`endif

endmodule

// File: tb/tb_parity_frame_rx_ctrl.sv
// Directed self-checking bench for parity_frame_rx_ctrl; err_cnt expectations follow PARITY_ERR_CNT_EN.
module tb_parity_frame_rx_ctrl;

  localparam int ERR_CNT_W = 2;
`ifdef PARITY_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   exp_cnt;

  parity_frame_rx_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

  parity_frame_rx_ctrl #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.sin_valid = 1'b1;
    bus.sin       = b;
    tick();
    bus.sin_valid = 1'b0;
    bus.sin       = 1'b0;
  endtask

  // bits[4:1] = a,b,c,d ; bits[0] = p
  task automatic send_frame(input logic [4:0] bits, input int gap, input bit clr_last);
    for (int i = 4; i >= 0; i--) begin
      if (i == 0) bus.err_clr = clr_last;
      send_bit(bits[i]);
      bus.err_clr = 1'b0;
      if (i != 0) begin
        repeat (gap) tick();
        check("no_valid_mid", {31'd0, bus.frame_valid}, 32'd0);
      end
    end
  endtask

  task automatic check_hold(input string tag, input logic [4:0] bits, input bit cleared);
    logic pec;
    pec = ^bits;
    if (cleared) exp_cnt = 0;
    else if (pec && exp_cnt < 3) exp_cnt++;
    check({tag, "_valid"}, {31'd0, bus.frame_valid}, 32'd1);
    check({tag, "_busy"},  {31'd0, bus.busy}, 32'd1);
    check({tag, "_data"},  {28'd0, bus.data_out}, {28'd0, bits[4:1]});
    check({tag, "_pec"},   {31'd0, bus.pec_err}, {31'd0, pec});
    check({tag, "_cnt"},   {30'd0, bus.err_cnt}, CNT_EN ? exp_cnt : 0);
  endtask

  task automatic ack();
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    check("ack_valid", {31'd0, bus.frame_valid}, 32'd0);
    check("ack_busy",  {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic full_frame(input string tag, input logic [4:0] bits, input int gap);
    do_start();
    check({tag, "_busy_start"}, {31'd0, bus.busy}, 32'd1);
    send_frame(bits, gap, 1'b0);
    check_hold(tag, bits, 1'b0);
    ack();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_cnt  = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.sin_valid = 1'b0;
    bus.sin       = 1'b0;
    bus.abort     = 1'b0;
    bus.frame_ack = 1'b0;
    bus.err_clr   = 1'b0;
    #12;
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_valid", {31'd0, bus.frame_valid}, 32'd0);
    check("rst_data",  {28'd0, bus.data_out}, 32'd0);
    check("rst_pec",   {31'd0, bus.pec_err}, 32'd0);
    check("rst_cnt",   {30'd0, bus.err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Clean frame, with start+ack coincident in HOLD (start must be ignored).
    do_start();
    check("clean_busy_start", {31'd0, bus.busy}, 32'd1);
    send_frame(5'b1011_1, 0, 1'b0);
    check_hold("clean", 5'b1011_1, 1'b0);
    bus.start = 1'b1;
    ack();
    bus.start = 1'b0;
    tick();
    check("hold_start_ignored", {31'd0, bus.busy}, 32'd0);

    // Abort after 3 bits; abort coincides with a valid bit.
    do_start();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.abort     = 1'b1;
    bus.sin_valid = 1'b1;
    bus.sin       = 1'b1;
    tick();
    bus.abort     = 1'b0;
    bus.sin_valid = 1'b0;
    bus.sin       = 1'b0;
    check("abort_busy",  {31'd0, bus.busy}, 32'd0);
    check("abort_valid", {31'd0, bus.frame_valid}, 32'd0);
    check("abort_data",  {28'd0, bus.data_out}, 32'h0000000b);
    check("abort_pec",   {31'd0, bus.pec_err}, 32'd0);
    check("abort_cnt",   {30'd0, bus.err_cnt}, 32'd0);

    // Bad parity frames; start and sin_valid in HOLD are ignored.
    do_start();
    send_frame(5'b1011_0, 0, 1'b0);
    check_hold("bad1", 5'b1011_0, 1'b0);
    bus.start = 1'b1;
    send_bit(1'b0);
    bus.start = 1'b0;
    tick();
    check("hold_stable_valid", {31'd0, bus.frame_valid}, 32'd1);
    check("hold_stable_data",  {28'd0, bus.data_out}, 32'h0000000b);
    check("hold_stable_pec",   {31'd0, bus.pec_err}, 32'd1);
    ack();
    full_frame("bad2", 5'b0000_1, 0);

    // Gapped input.
    full_frame("gap", 5'b0110_0, 3);

    // start with sin_valid in the same IDLE cycle: that bit is dropped.
    bus.sin_valid = 1'b1;
    bus.sin       = 1'b1;
    do_start();
    bus.sin_valid = 1'b0;
    bus.sin       = 1'b0;
    send_frame(5'b1100_0, 0, 1'b0);
    check_hold("startbit", 5'b1100_0, 1'b0);
    ack();

    // Asynchronous reset after two bits of a frame.
    do_start();
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy",  {31'd0, bus.busy}, 32'd0);
    check("arst_valid", {31'd0, bus.frame_valid}, 32'd0);
    check("arst_data",  {28'd0, bus.data_out}, 32'd0);
    check("arst_pec",   {31'd0, bus.pec_err}, 32'd0);
    check("arst_cnt",   {30'd0, bus.err_cnt}, 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    full_frame("post_rst", 5'b1111_0, 0);

    // Saturation at 3, then clear coinciding with a bad-frame completion.
    for (int k = 0; k < 4; k++) full_frame("sat", 5'b0000_1, 0);
    do_start();
    send_frame(5'b0000_1, 0, 1'b1);
    check_hold("clr", 5'b0000_1, 1'b1);
    ack();
    full_frame("after_clr", 5'b0001_0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule
